// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, oversampling ratio
// and the parity helper used by the transmitter (and by the matching receiver).
package uart_pkg;

    // Transmitter FSM states; 3-bit encoding leaves spare codes that recover to idle.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Parity selection for the PARITY parameter.
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // s_tick pulses per bit period; the receiver uses the same ratio.
    localparam int OVERSAMPLE = 16;

    // Last tick index inside one bit period, sized to the tick counter.
    localparam logic [5:0] OS_LAST = 6'(OVERSAMPLE - 1);

    // Parity bit for a (zero-extended) data word: even parity is the XOR of the
    // data bits, odd parity is its complement. Zero extension does not change it.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        logic p;
        p = ^data;
        if (mode == PARITY_ODD) begin
            p = ~p;
        end else begin
            p = p;
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: serialises one word as start bit, LSB-first data bits,
// optional parity bit and a stop period, paced by a shared 16x s_tick enable.
// The serial line is always driven straight from a flop so it never glitches.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY     = PARITY_NONE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_tick,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  tx_ready,
    output logic                  tx_done,
    output logic                  tx
);

    // Last tick of the stop period and index of the last data bit.
    localparam logic [5:0] STOP_LAST = 6'(SB_TICK - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_WIDTH - 1);
    localparam logic       HAS_PAR   = (PARITY != PARITY_NONE);

    uart_state_e           state_q, state_d;
    logic [5:0]            s_q, s_d;        // ticks elapsed in the current bit
    logic [2:0]            n_q, n_d;        // data bit index
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;

    // Next-state logic: advance through the frame on s_tick boundaries.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    // A tick arriving in the accept cycle is deliberately not counted.
                    shift_d = din;
                    par_d   = parity_bit(8'(din), PARITY);
                    s_d     = 6'd0;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_q == OS_LAST) begin
                        s_d     = 6'd0;
                        n_d     = 3'd0;
                        state_d = ST_DATA;
                    end else begin
                        s_d = s_q + 6'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_q == OS_LAST) begin
                        s_d     = 6'd0;
                        shift_d = shift_q >> 1;
                        if (n_q == BIT_LAST) begin
                            if (HAS_PAR) begin
                                state_d = ST_PARITY;
                            end else begin
                                state_d = ST_STOP;
                            end
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 6'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (s_q == OS_LAST) begin
                        s_d     = 6'd0;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 6'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (s_q == STOP_LAST) begin
                        s_d     = 6'd0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        s_d = s_q + 6'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end
            default: begin
                // Unknown encoding: fall back to a clean idle line.
                state_d = ST_IDLE;
                s_d     = 6'd0;
                n_d     = 3'd0;
                shift_d = '0;
                par_d   = 1'b0;
            end
        endcase
    end

    // Line level for the upcoming state, so the tx flop changes with the state.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset drops any frame and releases the line high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= 6'd0;
            n_q     <= 3'd0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx       = tx_q;
    assign tx_done  = done_q;
    assign tx_ready = (state_q == ST_IDLE);

endmodule
